// File: rtl/expr_eval.sv
// expr_eval
//   Evaluates a stream of single-digit ASCII expressions built from '+' and
//   '*'. Multiplication binds tighter than addition. The block publishes the
//   running value, a flag that is set while the input so far forms a complete
//   expression, and sticky syntax-error and overflow flags.
//
//   State table
//     state | meaning
//     IDLE  | no character consumed since reset
//     NUM   | last character was a digit; the expression is complete
//     OP    | last character was an operator; a digit must follow
//     ERR   | syntax error seen; only clr_i leaves this state
//
//   Ports
//     clk_i     in  1  clock; all state changes on the rising edge
//     clr_i     in  1  synchronous active-high reset; overrides in_vld_i
//     in_i      in  8  ASCII character: '0'-'9', '+' or '*'
//     in_vld_i  in  1  in_i is consumed this cycle
//     value_o   out W  registered running value (sum + prod) mod 2**W
//     ok_o      out 1  input so far forms a complete valid expression
//     err_o     out 1  sticky syntax error
//     ovf_o     out 1  sticky arithmetic overflow
module expr_eval #(
   parameter int W = 16
) (
   input  logic         clk_i,
   input  logic         clr_i,
   input  logic [7:0]   in_i,
   input  logic         in_vld_i,
   output logic [W-1:0] value_o,
   output logic         ok_o,
   output logic         err_o,
   output logic         ovf_o
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] NUM  = 2'd1;
   localparam logic [1:0] OP   = 2'd2;
   localparam logic [1:0] ERR  = 2'd3;

   localparam logic PEND_ADD = 1'b0;
   localparam logic PEND_MUL = 1'b1;

   localparam logic [7:0] CH_0    = 8'h30;
   localparam logic [7:0] CH_9    = 8'h39;
   localparam logic [7:0] CH_PLUS = 8'h2B;
   localparam logic [7:0] CH_STAR = 8'h2A;

   logic [1:0]   state_q, state_d;
   logic [W-1:0] sum_q, sum_d;
   logic [W-1:0] prod_q, prod_d;
   logic         pend_q, pend_d;
   logic [W-1:0] value_q, value_d;
   logic         ok_q, ok_d;
   logic         err_q, err_d;
   logic         ovf_q, ovf_d;

   logic         is_digit;
   logic [7:0]   digit_byte;
   logic [3:0]   digit;
   logic [W+3:0] mul_full;
   logic [W:0]   acc_full;
   logic [W:0]   val_full;
   logic         ovf_hit;

   assign is_digit   = (in_i >= CH_0) && (in_i <= CH_9);
   assign digit_byte = in_i - CH_0;
   assign digit      = digit_byte[3:0];

   // Wide products/sums so that any carry above bit W-1 is visible.
   assign mul_full = {4'b0000, prod_q} * {{W{1'b0}}, digit};
   assign acc_full = {1'b0, sum_q} + {1'b0, prod_q};

   always_comb begin
      state_d  = state_q;
      sum_d    = sum_q;
      prod_d   = prod_q;
      pend_d   = pend_q;
      ovf_hit  = 1'b0;

      if (in_vld_i && (state_q != ERR)) begin
         case (state_q)
            IDLE, OP: begin
               if (is_digit) begin
                  if (pend_q == PEND_MUL) begin
                     prod_d  = mul_full[W-1:0];
                     ovf_hit = |mul_full[W+3:W];
                  end else begin
                     prod_d  = {{(W-4){1'b0}}, digit};
                  end
                  state_d = NUM;
               end else begin
                  state_d = ERR;
               end
            end
            NUM: begin
               if (in_i == CH_PLUS) begin
                  sum_d   = acc_full[W-1:0];
                  ovf_hit = acc_full[W];
                  prod_d  = '0;
                  pend_d  = PEND_ADD;
                  state_d = OP;
               end else if (in_i == CH_STAR) begin
                  pend_d  = PEND_MUL;
                  state_d = OP;
               end else begin
                  state_d = ERR;
               end
            end
            default: state_d = ERR;
         endcase

         // Entering ERR discards this character's arithmetic entirely.
         if (state_d == ERR) begin
            sum_d   = sum_q;
            prod_d  = prod_q;
            pend_d  = pend_q;
            ovf_hit = 1'b0;
         end
      end
   end

   assign val_full = {1'b0, sum_d} + {1'b0, prod_d};

   always_comb begin
      value_d = value_q;
      ok_d    = ok_q;
      err_d   = err_q;
      ovf_d   = ovf_q;
      if (in_vld_i && (state_q != ERR)) begin
         if (state_d == ERR) begin
            err_d = 1'b1;
            ok_d  = 1'b0;
         end else begin
            value_d = val_full[W-1:0];
            ok_d    = (state_d == NUM);
            ovf_d   = ovf_q | ovf_hit | val_full[W];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         state_q <= IDLE;
         sum_q   <= '0;
         prod_q  <= '0;
         pend_q  <= PEND_ADD;
         value_q <= '0;
         ok_q    <= 1'b0;
         err_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sum_q   <= sum_d;
         prod_q  <= prod_d;
         pend_q  <= pend_d;
         value_q <= value_d;
         ok_q    <= ok_d;
         err_q   <= err_d;
         ovf_q   <= ovf_d;
      end
   end

   assign value_o = value_q;
   assign ok_o    = ok_q;
   assign err_o   = err_q;
   assign ovf_o   = ovf_q;

endmodule

// File: tb/tb_expr_eval.sv
module tb_expr_eval;

   localparam int W = 8;

   logic         clk_i = 1'b0;
   logic         clr_i;
   logic [7:0]   in_i;
   logic         in_vld_i;
   logic [W-1:0] value_o;
   logic         ok_o, err_o, ovf_o;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic         clr;
      logic         vld;
      logic [7:0]   ch;
      logic [W-1:0] value;
      logic         ok;
      logic         err;
      logic         ovf;
   } vec_t;

   vec_t vecs[$];

   expr_eval #(.W(W)) dut (
      .clk_i    (clk_i),
      .clr_i    (clr_i),
      .in_i     (in_i),
      .in_vld_i (in_vld_i),
      .value_o  (value_o),
      .ok_o     (ok_o),
      .err_o    (err_o),
      .ovf_o    (ovf_o)
   );

   always #5 clk_i = ~clk_i;

   initial begin
      #200000;
      $display("FAIL watchdog: run did not finish, value=%0d required=finish", value_o);
      $fatal(1, "watchdog");
   end

   task automatic add(input logic c, input logic v, input logic [7:0] ch,
                      input int val, input logic ok, input logic er, input logic ov);
      vec_t t;
      t.clr = c; t.vld = v; t.ch = ch;
      t.value = W'(val); t.ok = ok; t.err = er; t.ovf = ov;
      vecs.push_back(t);
   endtask

   task automatic step(input logic c, input logic v, input logic [7:0] ch);
      @(negedge clk_i);
      clr_i    = c;
      in_vld_i = v;
      in_i     = ch;
      @(posedge clk_i);
      #1;
   endtask

   task automatic check(input string name, input logic [W-1:0] val,
                        input logic ok, input logic er, input logic ov);
      n_checks++;
      if (value_o === val && ok_o === ok && err_o === er && ovf_o === ov)
         n_pass++;
      else
         $display("FAIL %s: got value=%0d ok=%b err=%b ovf=%b, required value=%0d ok=%b err=%b ovf=%b",
                  name, value_o, ok_o, err_o, ovf_o, val, ok, er, ov);
   endtask

   initial begin
      clr_i = 1'b1; in_vld_i = 1'b0; in_i = 8'h00;

      // reset
      add(1, 0, "x", 0, 0, 0, 0);
      // 1+2*3
      add(0, 1, "1", 1, 1, 0, 0);
      add(0, 1, "+", 1, 0, 0, 0);
      add(0, 1, "2", 3, 1, 0, 0);
      add(0, 1, "*", 3, 0, 0, 0);
      add(0, 1, "3", 7, 1, 0, 0);
      // 1+*3 : error at '*', value frozen, clr clears
      add(1, 0, "x", 0, 0, 0, 0);
      add(0, 1, "1", 1, 1, 0, 0);
      add(0, 1, "+", 1, 0, 0, 0);
      add(0, 1, "*", 1, 0, 1, 0);
      add(0, 1, "3", 1, 0, 1, 0);
      add(1, 0, "x", 0, 0, 0, 0);
      // 9* then clr with a valid '9', then 2+1
      add(0, 1, "9", 9, 1, 0, 0);
      add(0, 1, "*", 9, 0, 0, 0);
      add(1, 1, "9", 0, 0, 0, 0);
      add(0, 1, "2", 2, 1, 0, 0);
      add(0, 1, "+", 2, 0, 0, 0);
      add(0, 1, "1", 3, 1, 0, 0);
      // 9*9*9 = 729 -> 217 with overflow on last digit; clr clears ovf
      add(1, 0, "x", 0, 0, 0, 0);
      add(0, 1, "9", 9, 1, 0, 0);
      add(0, 1, "*", 9, 0, 0, 0);
      add(0, 1, "9", 81, 1, 0, 0);
      add(0, 1, "*", 81, 0, 0, 0);
      add(0, 1, "9", 217, 1, 0, 1);
      add(0, 0, "+", 217, 1, 0, 1);
      add(1, 0, "x", 0, 0, 0, 0);
      // 4+5 with idle gaps; garbage on in_i while invalid must be ignored
      add(0, 1, "4", 4, 1, 0, 0);
      add(0, 0, "a", 4, 1, 0, 0);
      add(0, 0, "7", 4, 1, 0, 0);
      add(0, 0, "+", 4, 1, 0, 0);
      add(0, 1, "+", 4, 0, 0, 0);
      add(0, 0, "*", 4, 0, 0, 0);
      add(0, 0, "a", 4, 0, 0, 0);
      add(0, 0, "3", 4, 0, 0, 0);
      add(0, 1, "5", 9, 1, 0, 0);
      add(0, 0, "1", 9, 1, 0, 0);
      // pend returns to ADD after '+': 2*3+4 = 10
      add(1, 0, "x", 0, 0, 0, 0);
      add(0, 1, "2", 2, 1, 0, 0);
      add(0, 1, "*", 2, 0, 0, 0);
      add(0, 1, "3", 6, 1, 0, 0);
      add(0, 1, "+", 6, 0, 0, 0);
      add(0, 1, "4", 10, 1, 0, 0);
      // precedence: 2+3*4 = 14
      add(1, 0, "x", 0, 0, 0, 0);
      add(0, 1, "2", 2, 1, 0, 0);
      add(0, 1, "+", 2, 0, 0, 0);
      add(0, 1, "3", 5, 1, 0, 0);
      add(0, 1, "*", 5, 0, 0, 0);
      add(0, 1, "4", 14, 1, 0, 0);
      // syntax errors: "12", "a", leading '+'; ERR absorbs later valid input
      add(1, 0, "x", 0, 0, 0, 0);
      add(0, 1, "1", 1, 1, 0, 0);
      add(0, 1, "2", 1, 0, 1, 0);
      add(1, 0, "x", 0, 0, 0, 0);
      add(0, 1, "a", 0, 0, 1, 0);
      add(1, 0, "x", 0, 0, 0, 0);
      add(0, 1, "+", 0, 0, 1, 0);
      add(0, 1, "5", 0, 0, 1, 0);
      add(0, 1, "*", 0, 0, 1, 0);
      add(1, 0, "x", 0, 0, 0, 0);

      for (int i = 0; i < vecs.size(); i++) begin
         step(vecs[i].clr, vecs[i].vld, vecs[i].ch);
         check($sformatf("vec%0d", i), vecs[i].value, vecs[i].ok, vecs[i].err, vecs[i].ovf);
      end

      // Long chain "1+1+...+1" with 40 ones -> 40; checked at every step.
      step(1, 0, "x");
      for (int k = 1; k <= 40; k++) begin
         step(0, 1, "1");
         check($sformatf("chain_digit%0d", k), W'(k), 1'b1, 1'b0, 1'b0);
         if (k != 40) begin
            step(0, 1, "+");
            check($sformatf("chain_plus%0d", k), W'(k), 1'b0, 1'b0, 1'b0);
         end
      end

      // 9*9*9*9*... keeps wrapping; ovf stays set once raised, ok stays 1.
      step(1, 0, "x");
      step(0, 1, "9");
      step(0, 1, "*");
      step(0, 1, "9");
      step(0, 1, "*");
      step(0, 1, "9");
      step(0, 1, "*");
      step(0, 1, "1");
      check("wrap_times1", 8'd217, 1'b1, 1'b0, 1'b1);
      step(0, 1, "+");
      step(0, 1, "0");
      check("wrap_plus0", 8'd217, 1'b1, 1'b0, 1'b1);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
